regfile_nrd: RTL and testbench

- Parametrised successor to the 32x1 operand mux: a WIDTH x NREGS register file with NRD independent registered read ports and one write port.
- Each read port is an NREGS:1 selector with a 1-cycle registered output and a valid strobe.
- Feeds ALU operand buses in the SPARC V8 datapath.
- Register 0 is optionally hardwired to zero (SPARC %g0 semantics).

---
 rtl/regfile_nrd_pkg.sv | 14 +
 rtl/regfile_nrd_if.sv | 30 +++
 rtl/regfile_nrd_mux_nx1.sv | 22 ++
 rtl/regfile_nrd.sv | 101 ++++++++++
 tb/tb_regfile_nrd.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/regfile_nrd_pkg.sv
// Shared types and helpers for the SPARC register-file slice.
package sparc_rf_pkg;

  localparam int RF_WIDTH = 32;
  localparam int RF_NREGS = 32;

  typedef logic [RF_WIDTH-1:0] rf_word_t;

  // An address bus is never narrower than one bit, even for a 2-entry file.
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_nrd_if.sv
// Write port plus NRD flattened read ports of the register file.
interface regfile_nrd_if
  import sparc_rf_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH,
  parameter int NREGS = RF_NREGS,
  parameter int NRD   = 2
);
  localparam int AW = clog2_safe(NREGS);

  logic                 we;
  logic [AW-1:0]        waddr;
  logic [WIDTH-1:0]     wdata;
  logic [NRD-1:0]       re;
  logic [NRD*AW-1:0]    raddr;
  logic [NRD*WIDTH-1:0] rdata;
  logic [NRD-1:0]       rvalid;
  logic [NRD-1:0]       rerr;

  modport master (
    output we, waddr, wdata, re, raddr,
    input  rdata, rvalid, rerr
  );

  modport slave (
    input  we, waddr, wdata, re, raddr,
    output rdata, rvalid, rerr
  );

endinterface

// File: rtl/regfile_nrd_mux_nx1.sv
// Combinational N:1 word selector; out-of-range selects give zero and raise oor.
module mux_nx1 #(
  parameter int N  = 32,
  parameter int W  = 32,
  parameter int SW = 5
) (
  input  logic [N*W-1:0] din,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   dout,
  output logic           oor
);

  always_comb begin
    dout = '0;
    oor  = 1'b1;
    if (int'(sel) < N) begin
      dout = din[int'(sel)*W +: W];
      oor  = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_nrd.sv
// WIDTH x NREGS flop register file, one write port, NRD registered read ports.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching reads.
module regfile_nrd
  import sparc_rf_pkg::*;
#(
  parameter int WIDTH   = RF_WIDTH,
  parameter int NREGS   = RF_NREGS,
  parameter int NRD     = 2,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  regfile_nrd_if.slave  rf
);

  localparam int AW = clog2_safe(NREGS);

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [NREGS-1:0][WIDTH-1:0] regs_q;
  logic [NREGS-1:0][WIDTH-1:0] rd_src;
  logic                        wr_ok;

  logic [NRD-1:0][WIDTH-1:0]   mux_dout;
  logic [NRD-1:0]              mux_oor;
  logic [NRD-1:0]              byp_hit;

  logic [NRD-1:0][WIDTH-1:0]   rdata_q, rdata_d;
  logic [NRD-1:0]              rvalid_q, rvalid_d;
  logic [NRD-1:0]              rerr_q, rerr_d;

  // Writes to missing registers or to a hardwired r0 are dropped.
  assign wr_ok = rf.we && (int'(rf.waddr) < NREGS) &&
                 !(ZERO_R0 && (rf.waddr == '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '0;
    end else if (wr_ok) begin
      regs_q[rf.waddr] <= rf.wdata;
    end
  end

  always_comb begin
    rd_src = regs_q;
    if (ZERO_R0) rd_src[0] = '0;
  end

  for (genvar p = 0; p < NRD; p++) begin : g_port
    logic [AW-1:0] addr;
    assign addr = rf.raddr[p*AW +: AW];

    mux_nx1 #(
      .N  (NREGS),
      .W  (WIDTH),
      .SW (AW)
    ) u_mux (
      .din  (rd_src),
      .sel  (addr),
      .dout (mux_dout[p]),
      .oor  (mux_oor[p])
    );

    // wr_ok already excludes r0 and out-of-range targets.
    assign byp_hit[p] = BYPASS && wr_ok && (addr == rf.waddr);
  end

  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = '0;
    rerr_d   = '0;
    for (int p = 0; p < NRD; p++) begin
      if (rf.re[p]) begin
        rvalid_d[p] = 1'b1;
        rerr_d[p]   = mux_oor[p];
        rdata_d[p]  = byp_hit[p] ? rf.wdata : mux_dout[p];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q  <= '0;
      rvalid_q <= '0;
      rerr_q   <= '0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      rerr_q   <= rerr_d;
    end
  end

  assign rf.rdata  = rdata_q;
  assign rf.rvalid = rvalid_q;
  assign rf.rerr   = rerr_q;

endmodule

// File: tb/tb_regfile_nrd.sv
// Scoreboard bench for regfile_nrd (24 registers, 2 read ports, r0 hardwired).
module tb_regfile_nrd;

  localparam int NREGS = 24;
  localparam int W     = 32;

`ifdef REGFILE_BYPASS_EN
  localparam bit MODEL_BYPASS = 1'b1;
`else
  localparam bit MODEL_BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_nrd_if #(.WIDTH(W), .NREGS(NREGS), .NRD(2)) rf();

  regfile_nrd #(
    .WIDTH   (W),
    .NREGS   (NREGS),
    .NRD     (2),
    .ZERO_R0 (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .rf    (rf)
  );

  typedef struct {
    logic [1:0]        vld;
    logic [1:0]        err;
    logic [1:0][W-1:0] d;
  } exp_t;

  exp_t        sbq[$];
  logic [W-1:0] mem [NREGS];
  logic [W-1:0] last [2];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string name, input int port, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s port%0d: got %h expected %h at %0t", name, port, got, exp, $time);
    end
  endtask

  // Reference model: each issued cycle yields the expected registered outputs.
  task automatic issue(input bit rst, input bit we, input int wa, input logic [W-1:0] wd,
                       input bit [1:0] re, input int a0, input int a1);
    exp_t e;
    int   a;
    @(negedge clk);
    reset    = rst;
    rf.we    = we;
    rf.waddr = wa[4:0];
    rf.wdata = wd;
    rf.re    = re;
    rf.raddr = {a1[4:0], a0[4:0]};
    for (int p = 0; p < 2; p++) begin
      a = (p == 0) ? a0 : a1;
      e.vld[p] = 1'b0;
      e.err[p] = 1'b0;
      if (rst) begin
        last[p] = '0;
      end else if (re[p]) begin
        e.vld[p] = 1'b1;
        e.err[p] = (a >= NREGS);
        if (a >= NREGS || a == 0)                last[p] = '0;
        else if (MODEL_BYPASS && we && wa == a)  last[p] = wd;
        else                                     last[p] = mem[a];
      end
      e.d[p] = last[p];
    end
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] = '0;
    end else if (we && wa > 0 && wa < NREGS) begin
      mem[wa] = wd;
    end
    sbq.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    reset = 1'b0;
    rf.we = 1'b0;
    rf.re = 2'b00;
  endtask

  // Monitor: one expectation per issued cycle, sampled just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("rvalid", 0, {30'd0, rf.rvalid}, {30'd0, e.vld});
        for (int p = 0; p < 2; p++) begin
          chk("rdata", p, rf.rdata[p*W +: W], e.d[p]);
          if (e.vld[p]) chk("rerr", p, {31'd0, rf.rerr[p]}, {31'd0, e.err[p]});
        end
      end
    end
  end

  initial begin
    int a0, a1, wa;
    bit [1:0] re;
    reset    = 1'b1;
    rf.we    = 1'b0;
    rf.waddr = '0;
    rf.wdata = '0;
    rf.re    = '0;
    rf.raddr = '0;
    for (int i = 0; i < NREGS; i++) mem[i] = '0;
    last[0] = '0;
    last[1] = '0;

    issue(1, 0, 0, 0, 2'b00, 0, 0);
    issue(0, 0, 0, 0, 2'b11, 0, 5);
    issue(0, 1, 7, 32'hDEAD_BEEF, 2'b00, 0, 0);
    issue(0, 0, 0, 0, 2'b01, 7, 0);
    issue(0, 0, 0, 0, 2'b00, 0, 0);
    issue(0, 1, 0, 32'hFFFF_FFFF, 2'b00, 0, 0);
    issue(0, 0, 0, 0, 2'b11, 0, 0);
    issue(0, 1, 0, 32'h1234_5678, 2'b11, 0, 0);
    issue(0, 1, 3, 32'h11, 2'b00, 0, 0);
    issue(0, 1, 3, 32'h22, 2'b01, 3, 0);
    issue(0, 0, 0, 0, 2'b11, 3, 3);
    issue(0, 0, 0, 0, 2'b11, 30, 23);
    issue(0, 1, 30, 32'hA5A5_A5A5, 2'b00, 0, 0);
    for (int i = 0; i < NREGS; i += 2) issue(0, 0, 0, 0, 2'b11, i, i + 1);
    issue(0, 1, 9, 32'h5A, 2'b00, 0, 0);
    issue(1, 0, 0, 0, 2'b01, 9, 0);
    issue(0, 0, 0, 0, 2'b11, 9, 7);

    for (int n = 0; n < 400; n++) begin
      wa = $urandom_range(0, 31);
      a0 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 31);
      a1 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 31);
      re = 2'($urandom_range(0, 3));
      issue(($urandom_range(0, 59) == 0), $urandom_range(0, 1) == 1, wa, $urandom,
            re, a0, a1);
    end

    idle();
    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
    #2;
    if (sbq.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
